// File: rtl/mapa_pkg.sv
// mapa_pkg: shared constants, types and state encoding for the map-selection
// and matrix-scan controller of the 7x5 LED matrix game.
// Ports: none (package).

package mapa_pkg;

  localparam int NUM_MAPAS  = 8;
  localparam int NUM_COLS   = 5;
  localparam int NUM_LINHAS = 7;

  typedef logic [$clog2(NUM_MAPAS)-1:0] sel_t;
  typedef logic [$clog2(NUM_COLS)-1:0]  col_idx_t;
  typedef logic [NUM_LINHAS-1:0]        coluna_t;

  // Two-state controller; kept as plain constants so legacy code can share them.
  localparam logic [0:0] SELECAO = 1'b0;
  localparam logic [0:0] JOGO    = 1'b1;

  // Index of the column that follows idx in the left-rotating scan.
  function automatic col_idx_t prox_col(input col_idx_t idx);
    if (idx == col_idx_t'(NUM_COLS - 1)) begin
      return '0;
    end
    return idx + col_idx_t'(1);
  endfunction

endpackage

// File: rtl/detector_borda.sv
// detector_borda: 2-flop synchronizer followed by a rising-edge detector that
// turns each button press into exactly one single-cycle pulse.
// Ports: clk, reset (async, active-high), i_btn (async level), o_pulso (1-cycle event).

module detector_borda (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulso
);

  logic       r_s1;
  logic       r_s2;
  logic       r_ant;
  logic [1:0] r_aquec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_ant   <= 1'b0;
      r_aquec <= 2'd0;
    end else begin
      r_s1  <= i_btn;
      r_s2  <= r_s1;
      r_ant <= r_s2;
      if (r_aquec != 2'd3) begin
        r_aquec <= r_aquec + 2'd1;
      end
    end
  end

  // The edge is only trusted once r_ant holds a level actually sampled from
  // the pin (three edges after reset release). Before that, r_ant still holds
  // the cleared value, and a button held through reset would look like a press.
  assign o_pulso = r_s2 & ~r_ant & (r_aquec == 2'd3);

endmodule

// File: rtl/controle_mapa.sv
// controle_mapa: map-selection FSM (next/previous/confirm/restart buttons) that
// drives sel into seletor_mapa and captures the chosen map on confirm, plus a
// column-by-column scan of the live preview (SELECAO) or locked map (JOGO).
// Ports: clk, reset (async high), btn_prox/btn_ant/btn_conf/btn_reini (async
//   levels), mapa0..mapa4 (column data for current sel) -> sel, travado,
//   inicio (1-cycle lock pulse), mapa_salvo {mapa4..mapa0}, col (one-hot),
//   linha (row data of the active column).

module controle_mapa
  import mapa_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             btn_prox,
  input  logic                             btn_ant,
  input  logic                             btn_conf,
  input  logic                             btn_reini,
  input  logic [NUM_LINHAS-1:0]            mapa0,
  input  logic [NUM_LINHAS-1:0]            mapa1,
  input  logic [NUM_LINHAS-1:0]            mapa2,
  input  logic [NUM_LINHAS-1:0]            mapa3,
  input  logic [NUM_LINHAS-1:0]            mapa4,
  output logic [$clog2(NUM_MAPAS)-1:0]     sel,
  output logic                             travado,
  output logic                             inicio,
  output logic [NUM_COLS*NUM_LINHAS-1:0]   mapa_salvo,
  output logic [NUM_COLS-1:0]              col,
  output logic [NUM_LINHAS-1:0]            linha
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  if (SCAN_DIV < 2) begin : g_scan_div_invalido
    $error("controle_mapa: SCAN_DIV must be at least 2");
  end

  // Button events
  logic w_prox;
  logic w_ant;
  logic w_conf;
  logic w_reini;

  detector_borda u_det_prox (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_prox),
    .o_pulso (w_prox)
  );

  detector_borda u_det_ant (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_ant),
    .o_pulso (w_ant)
  );

  detector_borda u_det_conf (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_conf),
    .o_pulso (w_conf)
  );

  detector_borda u_det_reini (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_reini),
    .o_pulso (w_reini)
  );

  // Selection FSM, sel counter and capture register
  logic [0:0]                         r_estado;
  sel_t                               r_sel;
  logic                               r_travado;
  logic                               r_inicio;
  logic [NUM_COLS*NUM_LINHAS-1:0]     r_salvo;
  logic [NUM_COLS*NUM_LINHAS-1:0]     w_mapa_vivo;

  assign w_mapa_vivo = {mapa4, mapa3, mapa2, mapa1, mapa0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado  <= SELECAO;
      r_sel     <= '0;
      r_travado <= 1'b0;
      r_inicio  <= 1'b0;
      r_salvo   <= '0;
    end else begin
      r_inicio <= 1'b0;
      case (r_estado)
        SELECAO: begin
          // Confirm wins over navigation; sel is frozen on the capture cycle
          // so mapa_salvo matches the sel that is left on display.
          if (w_conf) begin
            r_salvo   <= w_mapa_vivo;
            r_travado <= 1'b1;
            r_inicio  <= 1'b1;
            r_estado  <= JOGO;
          end else if (w_prox && !w_ant) begin
            r_sel <= r_sel + sel_t'(1);
          end else if (w_ant && !w_prox) begin
            r_sel <= r_sel - sel_t'(1);
          end
        end
        JOGO: begin
          if (w_reini) begin
            r_travado <= 1'b0;
            r_estado  <= SELECAO;
          end
        end
        default: r_estado <= SELECAO;
      endcase
    end
  end

  // Column scan
  logic [DIV_W-1:0]     r_div;
  col_idx_t             r_idx;
  logic [NUM_COLS-1:0]  r_col;
  coluna_t              r_linha;

  logic                 w_wrap;
  col_idx_t             w_idx_prox;
  coluna_t              w_vivo_col  [NUM_COLS];
  coluna_t              w_salvo_col [NUM_COLS];
  coluna_t              w_dado_prox;

  assign w_wrap     = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_idx_prox = prox_col(r_idx);

  always_comb begin
    for (int c = 0; c < NUM_COLS; c++) begin
      w_vivo_col[c]  = w_mapa_vivo[c*NUM_LINHAS +: NUM_LINHAS];
      w_salvo_col[c] = r_salvo[c*NUM_LINHAS +: NUM_LINHAS];
    end
  end

  // Source is chosen by the state at load time, so a lock/unlock only shows
  // up at the next column boundary and linha never changes mid-column.
  always_comb begin
    w_dado_prox = w_vivo_col[w_idx_prox];
    if (r_estado == JOGO) begin
      w_dado_prox = w_salvo_col[w_idx_prox];
    end
  end

  // The scan is free-running: only reset touches it, never the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div   <= '0;
      r_idx   <= '0;
      r_col   <= NUM_COLS'(1);
      r_linha <= '0;
    end else if (w_wrap) begin
      r_div   <= '0;
      r_idx   <= w_idx_prox;
      r_col   <= {r_col[NUM_COLS-2:0], r_col[NUM_COLS-1]};
      r_linha <= w_dado_prox;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign sel        = r_sel;
  assign travado    = r_travado;
  assign inicio     = r_inicio;
  assign mapa_salvo = r_salvo;
  assign col        = r_col;
  assign linha      = r_linha;

endmodule

// File: tb/tb_controle_mapa.sv
module tb_controle_mapa;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        b_prox = 1'b0;
  logic        b_ant = 1'b0;
  logic        b_conf = 1'b0;
  logic        b_reini = 1'b0;
  logic [6:0]  m0, m1, m2, m3, m4;
  logic [2:0]  sel;
  logic        travado;
  logic        inicio;
  logic [34:0] mapa_salvo;
  logic [4:0]  col;
  logic [6:0]  linha;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_inicio = 0;

  always #5 clk = ~clk;

  controle_mapa #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_prox   (b_prox),
    .btn_ant    (b_ant),
    .btn_conf   (b_conf),
    .btn_reini  (b_reini),
    .mapa0      (m0),
    .mapa1      (m1),
    .mapa2      (m2),
    .mapa3      (m3),
    .mapa4      (m4),
    .sel        (sel),
    .travado    (travado),
    .inicio     (inicio),
    .mapa_salvo (mapa_salvo),
    .col        (col),
    .linha      (linha)
  );

  // Stand-in for seletor_mapa: column c of map m.
  function automatic logic [6:0] mapa_rom(input int m, input int c);
    if (m == 0 && c == 1) return 7'b0001100;
    if (m == 5 && c == 0) return 7'b1000000;
    if (m == 6 && c == 2) return 7'b0010011;
    return 7'((m * 37 + c * 11 + 3) % 128);
  endfunction

  function automatic logic [34:0] mapa_cheio(input int m);
    return {mapa_rom(m, 4), mapa_rom(m, 3), mapa_rom(m, 2), mapa_rom(m, 1), mapa_rom(m, 0)};
  endfunction

  always_comb begin
    m0 = mapa_rom(int'(sel), 0);
    m1 = mapa_rom(int'(sel), 1);
    m2 = mapa_rom(int'(sel), 2);
    m3 = mapa_rom(int'(sel), 3);
    m4 = mapa_rom(int'(sel), 4);
  end

  task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nome, got, exp, $time);
    end
  endtask

  task automatic falha(input string nome);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", nome, $time);
  endtask

  // Behavioural model: edges since release, press events delayed two edges,
  // scan position by plain division of the edge count.
  int   t;
  int   e_sel;
  int   e_state;
  bit   e_trav, e_ini;
  logic [34:0] e_salvo;
  logic [6:0]  e_linha;
  bit   cur[4], prev[4], d1[4], d2[4], eff[4];
  int   st_pre, sel_pre, idx;

  task automatic model_reset();
    t = 0; e_sel = 0; e_state = 0; e_trav = 0; e_ini = 0;
    e_salvo = '0; e_linha = '0;
    for (int b = 0; b < 4; b++) begin
      prev[b] = 0; d1[b] = 0; d2[b] = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        model_reset();
      end else begin
        t++;
        cur[0] = b_prox; cur[1] = b_ant; cur[2] = b_conf; cur[3] = b_reini;
        for (int b = 0; b < 4; b++) begin
          eff[b]  = d2[b];
          d2[b]   = d1[b];
          d1[b]   = (t >= 2) && cur[b] && !prev[b];
          prev[b] = cur[b];
        end
        st_pre  = e_state;
        sel_pre = e_sel;
        e_ini   = 0;
        if (e_state == 0) begin
          if (eff[2]) begin
            e_salvo = mapa_cheio(sel_pre);
            e_trav = 1; e_ini = 1; e_state = 1;
          end else if (eff[0] && !eff[1]) e_sel = (e_sel + 1) % 8;
          else if (eff[1] && !eff[0]) e_sel = (e_sel + 7) % 8;
        end else if (eff[3]) begin
          e_trav = 0; e_state = 0;
        end
        if (t % SCAN_DIV == 0) begin
          idx = (t / SCAN_DIV) % 5;
          e_linha = (st_pre == 0) ? mapa_rom(sel_pre, idx) : e_salvo[idx*7 +: 7];
        end
      end
      idx = (t / SCAN_DIV) % 5;
      n_inicio += int'(inicio);
      chk("sel", sel, e_sel);
      chk("travado", travado, e_trav);
      chk("inicio", inicio, e_ini);
      chk("mapa_salvo", mapa_salvo, e_salvo);
      chk("col", col, 5'b00001 << idx);
      chk("col onehot", $onehot(col), 1);
      chk("linha", linha, e_linha);
    end
  end

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: b_prox = v;
      1: b_ant = v;
      2: b_conf = v;
      default: b_reini = v;
    endcase
  endtask

  task automatic press(input int b, input int hold);
    @(negedge clk);
    set_btn(b, 1'b1);
    repeat (hold) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (6) @(negedge clk);
  endtask

  task automatic frames(input int n);
    int last, guard;
    logic [4:0] pv;
    last = -1;
    for (int i = 0; i <= n; i++) begin
      guard = 0;
      do begin
        pv = col;
        @(negedge clk);
        guard++;
      end while (!(pv == 5'b10000 && col == 5'b00001) && guard < 100);
      if (guard >= 100) begin
        falha("frame wrap");
        return;
      end
      if (last >= 0) chk("frame period", cyc - last, 5 * SCAN_DIV);
      last = cyc;
    end
  endtask

  int ni0, guard;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset sel", sel, 3'd0);
    chk("reset col", col, 5'b00001);
    chk("reset linha", linha, 7'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("first col advance", col, 5'b00010);
    chk("map0 col1", linha, 7'b0001100);

    press(0, 10); chk("prox 1", sel, 3'd1);
    press(0, 10); chk("prox 2", sel, 3'd2);
    press(0, 10); chk("prox 3", sel, 3'd3);
    press(1, 10); chk("ant 3->2", sel, 3'd2);
    press(1, 10); press(1, 10); chk("ant to 0", sel, 3'd0);
    press(1, 10); chk("ant wrap 0->7", sel, 3'd7);
    press(0, 10); chk("prox wrap 7->0", sel, 3'd0);

    @(negedge clk); b_prox = 1'b1; b_ant = 1'b1;
    repeat (3) @(negedge clk); b_prox = 1'b0; b_ant = 1'b0;
    repeat (6) @(negedge clk);
    chk("prox+ant cancel", sel, 3'd0);

    for (int i = 0; i < 5; i++) press(0, 4);
    chk("sel 5", sel, 3'd5);
    ni0 = n_inicio;
    @(negedge clk); b_prox = 1'b1; b_conf = 1'b1;
    repeat (4) @(negedge clk); b_prox = 1'b0; b_conf = 1'b0;
    repeat (6) @(negedge clk);
    chk("conf priority sel", sel, 3'd5);
    chk("locked", travado, 1'b1);
    chk("map5 col0 saved", mapa_salvo[6:0], 7'b1000000);
    chk("one inicio pulse", n_inicio - ni0, 1);
    press(3, 5); chk("unlock", travado, 1'b0);

    press(0, 5); press(2, 5);
    chk("lock map 6", travado, 1'b1);
    press(0, 5); press(1, 5); press(2, 5);
    chk("locked sel held", sel, 3'd6);
    chk("locked map held", mapa_salvo, mapa_cheio(6));
    guard = 0;
    while (col != 5'b00100 && guard < 50) begin @(negedge clk); guard++; end
    if (col != 5'b00100) falha("wait col 00100");
    else chk("map6 col2 in JOGO", linha, 7'b0010011);
    press(3, 5);
    chk("reini travado", travado, 1'b0);
    chk("reini sel", sel, 3'd6);
    press(0, 5); chk("back in SELECAO", sel, 3'd7);

    press(2, 5);
    @(posedge clk); #1; @(posedge clk); #3;
    reset = 1'b1; b_prox = 1'b1;
    #1;
    chk("async rst sel", sel, 3'd0);
    chk("async rst travado", travado, 1'b0);
    chk("async rst inicio", inicio, 1'b0);
    chk("async rst mapa_salvo", mapa_salvo, 35'd0);
    chk("async rst col", col, 5'b00001);
    chk("async rst linha", linha, 7'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    b_prox = 1'b0;
    repeat (6) @(negedge clk);
    chk("held through reset", sel, 3'd0);

    frames(20);
    press(2, 5);
    chk("lock for frames", travado, 1'b1);
    frames(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
